// File: rtl/sysid_checker.sv
// Avalon-MM master that reads the system-ID slave's ID and timestamp words and
// compares them against build-time values. Publishes pass/mismatch/timeout status.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1478015793,
  parameter bit          CHECK_TIMESTAMP    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, FINISH} state_t;

  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_nxt;
  logic        auto_pend;
  logic        rd_ack;
  logic        rd_stall;
  logic        chk_ok;

  assign rd_ack   = avm_read && !avm_waitrequest;
  assign rd_stall = avm_read && avm_waitrequest;
  assign tmo_nxt  = tmo_cnt + 16'd1;

  // Verdict is registered on the timestamp completion edge so it is valid in
  // the FINISH cycle, together with the done pulse.
  assign chk_ok = (id_value == EXPECTED_ID) &&
                  (!CHECK_TIMESTAMP || (avm_readdata == EXPECTED_TIMESTAMP));

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      auto_pend   <= AUTO_START;
      tmo_cnt     <= '0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      mismatch    <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || auto_pend) begin
            auto_pend   <= 1'b0;
            pass        <= 1'b0;
            mismatch    <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b1;
            tmo_cnt     <= '0;
            avm_read    <= 1'b1;
            avm_address <= 1'b0;
            state       <= RD_ID;
          end
        end
        RD_ID, RD_TS: begin
          // A completion always wins over a timeout in the same cycle.
          if (rd_ack) begin
            tmo_cnt <= '0;
            if (state == RD_ID) begin
              id_value    <= avm_readdata;
              avm_address <= 1'b1;
              state       <= RD_TS;
            end else begin
              ts_value <= avm_readdata;
              avm_read <= 1'b0;
              done     <= 1'b1;
              pass     <= chk_ok;
              mismatch <= !chk_ok;
              state    <= FINISH;
            end
          end else if (rd_stall) begin
            tmo_cnt <= tmo_nxt;
            if (tmo_nxt == TMO_LIM) begin
              avm_read <= 1'b0;
              timeout  <= 1'b1;
              pass     <= 1'b0;
              mismatch <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysid_checker.sv
// Directed bench: three checker instances (default, timestamp ignored,
// short timeout) each with its own scripted system-ID slave.
module tb_sysid_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s  [3];
  logic        wr       [3];
  logic [31:0] id_data  [3];
  logic [31:0] ts_data  [3];
  logic        addr_s   [3];
  logic        read_s   [3];
  logic [31:0] rdata    [3];
  logic        busy_s   [3];
  logic        done_s   [3];
  logic        pass_s   [3];
  logic        mis_s    [3];
  logic        tmo_s    [3];
  logic [31:0] idv_s    [3];
  logic [31:0] tsv_s    [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign rdata[0] = addr_s[0] ? ts_data[0] : id_data[0];
  assign rdata[1] = addr_s[1] ? ts_data[1] : id_data[1];
  assign rdata[2] = addr_s[2] ? ts_data[2] : id_data[2];

  sysid_checker u0 (
    .clock(clk), .reset(reset), .start(start_s[0]),
    .avm_address(addr_s[0]), .avm_read(read_s[0]), .avm_readdata(rdata[0]),
    .avm_waitrequest(wr[0]), .busy(busy_s[0]), .done(done_s[0]),
    .pass(pass_s[0]), .mismatch(mis_s[0]), .timeout(tmo_s[0]),
    .id_value(idv_s[0]), .ts_value(tsv_s[0]));

  sysid_checker #(.CHECK_TIMESTAMP(1'b0)) u1 (
    .clock(clk), .reset(reset), .start(start_s[1]),
    .avm_address(addr_s[1]), .avm_read(read_s[1]), .avm_readdata(rdata[1]),
    .avm_waitrequest(wr[1]), .busy(busy_s[1]), .done(done_s[1]),
    .pass(pass_s[1]), .mismatch(mis_s[1]), .timeout(tmo_s[1]),
    .id_value(idv_s[1]), .ts_value(tsv_s[1]));

  sysid_checker #(.TIMEOUT_CYCLES(4)) u2 (
    .clock(clk), .reset(reset), .start(start_s[2]),
    .avm_address(addr_s[2]), .avm_read(read_s[2]), .avm_readdata(rdata[2]),
    .avm_waitrequest(wr[2]), .busy(busy_s[2]), .done(done_s[2]),
    .pass(pass_s[2]), .mismatch(mis_s[2]), .timeout(tmo_s[2]),
    .id_value(idv_s[2]), .ts_value(tsv_s[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int ndone;
    int lat;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 1'b0;
      wr[i]      = 1'b0;
      id_data[i] = 32'd0;
    end
    ts_data[0] = 32'd1478015793;
    ts_data[1] = 32'h12345678;
    ts_data[2] = 32'h12345678;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_read", read_s[0], 0);
    chk("rst_addr", addr_s[0], 0);
    chk("rst_busy", busy_s[0], 0);
    chk("rst_done", done_s[0], 0);
    chk("rst_pass", pass_s[0], 0);
    chk("rst_tsv",  tsv_s[0], 0);
    reset = 1'b0;

    // auto check, no stalls
    @(negedge clk);
    chk("auto_c1_read", read_s[0], 1);
    chk("auto_c1_addr", addr_s[0], 0);
    chk("auto_c1_busy", busy_s[0], 1);
    @(negedge clk);
    chk("auto_c2_read", read_s[0], 1);
    chk("auto_c2_addr", addr_s[0], 1);
    chk("auto_c2_done", done_s[0], 0);
    @(negedge clk);
    chk("auto_c3_done", done_s[0], 1);
    chk("auto_c3_read", read_s[0], 0);
    chk("auto_c3_pass", pass_s[0], 1);
    chk("auto_c3_mis",  mis_s[0], 0);
    chk("auto_c3_tsv",  tsv_s[0], 32'd1478015793);
    chk("nots_pass",    pass_s[1], 1);
    chk("nots_tsv",     tsv_s[1], 32'h12345678);
    chk("tsbad_mis",    mis_s[2], 1);
    chk("tsbad_pass",   pass_s[2], 0);
    @(negedge clk);
    chk("auto_c4_done", done_s[0], 0);
    chk("auto_c4_busy", busy_s[0], 0);
    chk("auto_c4_pass", pass_s[0], 1);

    // three stall cycles on each read: done 9 cycles after start
    start_s[0] = 1'b1;
    wr[0]      = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start_s[0] = 1'b0;
      if (c <= 4) begin
        chk("stall_id_read", read_s[0], 1);
        chk("stall_id_addr", addr_s[0], 0);
      end else if (c <= 8) begin
        chk("stall_ts_read", read_s[0], 1);
        chk("stall_ts_addr", addr_s[0], 1);
      end
      chk("stall_done", done_s[0], (c == 9) ? 1 : 0);
      wr[0] = (c == 4 || c == 8) ? 1'b0 : 1'b1;
    end
    wr[0] = 1'b0;
    chk("stall_pass", pass_s[0], 1);
    chk("stall_tmo",  tmo_s[0], 0);

    // timeout on the ID read (limit 4)
    id_data[2] = 32'hDEADBEEF;
    start_s[2] = 1'b1;
    wr[2]      = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_s[2] = 1'b0;
      chk("tmo_read", read_s[2], (c <= 4) ? 1 : 0);
      chk("tmo_done", done_s[2], (c == 5) ? 1 : 0);
    end
    chk("tmo_flag", tmo_s[2], 1);
    chk("tmo_pass", pass_s[2], 0);
    chk("tmo_mis",  mis_s[2], 0);
    chk("tmo_busy", busy_s[2], 0);
    chk("tmo_idv",  idv_s[2], 0);
    wr[2] = 1'b0;

    // start during RD_TS and FINISH is ignored
    start_s[1] = 1'b1;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (done_s[1]) ndone++;
      start_s[1] = (c == 2 || c == 3) ? 1'b1 : 1'b0;
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_busy",  busy_s[1], 0);
    chk("ign_read",  read_s[1], 0);

    // second check after done refreshes status
    id_data[1] = 32'd5;
    start_s[1] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      start_s[1] = 1'b0;
    end
    chk("rerun_done", done_s[1], 1);
    chk("rerun_mis",  mis_s[1], 1);
    chk("rerun_pass", pass_s[1], 0);
    chk("rerun_idv",  idv_s[1], 5);
    @(negedge clk);

    // reset in RD_TS, then auto relaunch
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    chk("mid_rdts_addr", addr_s[0], 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_read", read_s[0], 0);
    chk("mid_rst_busy", busy_s[0], 0);
    chk("mid_rst_addr", addr_s[0], 0);
    chk("mid_rst_tsv",  tsv_s[0], 0);
    chk("mid_rst_done", done_s[0], 0);
    reset = 1'b0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done_s[0]) begin
        lat = k;
        break;
      end
    end
    chk("relaunch_lat",  lat, 3);
    chk("relaunch_pass", pass_s[0], 1);
    chk("relaunch_tsv",  tsv_s[0], 32'd1478015793);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sysid_checker.md
Name: sysid_checker

Overview:
- Avalon-MM master that sits directly downstream of the system-ID slave and consumes its readdata.
- Reads the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values.
- Publishes captured values plus pass/fail/timeout status, so boot logic and a status LED can reject a mismatched FPGA image before the Nios software runs.

Parameters:
EXPECTED_ID, 32'd0, value expected at slave address 0
EXPECTED_TIMESTAMP, 32'd1478015793, value expected at slave address 1
CHECK_TIMESTAMP, 1, 1 = timestamp mismatch fails the check; 0 = timestamp is captured only
TIMEOUT_CYCLES, 255, maximum waitrequest-stalled cycles per read (1..65535)
AUTO_START, 1, 1 = one check launches automatically on the first cycle after reset deasserts

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle pulse that launches a check; ignored while busy
avm_address  out  1  0 = ID word, 1 = timestamp word
avm_read  out  1  read strobe
avm_readdata  in  32  slave read data
avm_waitrequest  in  1  slave stall
busy  out  1  check in progress
done  out  1  one-cycle pulse when a check finishes (pass, fail or timeout)
pass  out  1  level: last check matched
mismatch  out  1  level: last check completed with a compare failure
timeout  out  1  level: last check aborted by timeout
id_value  out  32  captured ID word
ts_value  out  32  captured timestamp word

Behaviour:
- Reset values: avm_read=0, avm_address=0, busy=0, done=0, pass=0, mismatch=0, timeout=0, id_value=0, ts_value=0, timeout counter=0. FSM goes to IDLE.
- Zero-latency read protocol: a read completes in the first cycle where avm_read=1 and avm_waitrequest=0. avm_readdata is sampled in that cycle. avm_read and avm_address stay stable while waitrequest=1.
- FSM states: IDLE, RD_ID, RD_TS, FINISH.
- IDLE: a launch occurs on start=1, or on the first cycle after reset if AUTO_START=1. On launch: clear pass/mismatch/timeout, set busy=1, and next cycle enter RD_ID with avm_read=1 and avm_address=0.
- RD_ID: on completion, capture id_value, clear the counter, go to RD_TS with avm_address=1. avm_read stays high, giving back-to-back reads.
- RD_TS: on completion, capture ts_value, drop avm_read, go to FINISH.
- FINISH (1 cycle): evaluate from the captured registers.
  - ok = (id_value==EXPECTED_ID) && (!CHECK_TIMESTAMP || ts_value==EXPECTED_TIMESTAMP).
  - pass=ok, mismatch=!ok, done=1 for this cycle, busy=0, return to IDLE.
- Timeout: the counter increments each cycle avm_read=1 and waitrequest=1. When it reaches TIMEOUT_CYCLES:
  - drop avm_read and set timeout=1, pass=0, mismatch=0;
  - pulse done, go to IDLE.
  - Capture registers keep whatever was read so far; an uncompleted word keeps its previous value.
- Latency with no stalls: start sampled at cycle 0, avm_read high in cycles 1-2, done in cycle 3. pass/mismatch are valid from cycle 3 and hold until the next launch.
- Simultaneous events: a start in the FINISH cycle is ignored (busy still 1 that cycle). A completion in the same cycle the counter would hit the limit counts as a completion, not a timeout.
- Reset mid-check: abort immediately to reset values, with avm_read=0 in the cycle after reset is sampled. The AUTO_START relaunch then applies.
- The status levels pass/mismatch/timeout are mutually exclusive and at most one is set at any time.

Test Plan:
- Defaults, slave returns 0 / 1478015793, waitrequest=0, reset released -> auto check; avm_read high 2 cycles, addresses 0 then 1; done in cycle 3; pass=1, id_value=0, ts_value=1478015793.
- Slave address 1 returns 0x12345678, CHECK_TIMESTAMP=1 -> mismatch=1, pass=0, ts_value=0x12345678. Repeat with CHECK_TIMESTAMP=0 -> pass=1.
- waitrequest held 3 cycles on each read -> done 9 cycles after start; pass=1; address and read stable throughout each stall.
- TIMEOUT_CYCLES=4, waitrequest stuck high on the ID read -> avm_read drops after 4 stalled cycles; timeout=1, done pulse, pass=0, id_value unchanged.
- start pulsed during RD_TS and during FINISH -> ignored, exactly one done. start pulsed after done -> a second full check runs and pass is refreshed.
- reset asserted during RD_TS -> all outputs return to reset values. After release the auto check reruns and passes.
